// File: rtl/nios2_timer_multi.sv
// ============================================================================
// nios2_timer_multi
// ----------------------------------------------------------------------------
// Multi-channel interval timer for the Nios II data master. It provides
// NUM_CH independent down-counters of CNT_W bits behind a single 16-bit
// Avalon-MM slave. Each channel has its own interrupt, and all channel
// interrupts are ORed into one combined interrupt.
//
// Optional feature macro: NIOS2_TIMER_MULTI_PWM_EN
//   defined   : each channel has a compare register and a registered
//               pwm_out bit = RUN & PWM & (counter < compare).
//   undefined : compare registers are absent (they read 0 and writes are
//               ignored), the PWM control bit reads 0, and pwm_out is 0.
//
// Register map. Each channel occupies 8 word addresses: address[2:0] selects
// the register and address[ADDR_W-1:3] selects the channel.
//   0 status   {RUN[1], TO[0]}         any write clears TO
//   1 control  {PWM[4], STOP[3], START[2], CONT[1], ITO[0]}
//   2/3 period lo/hi                   a write forces a reload next cycle
//   4/5 snap   lo/hi                   a write captures the counter
//   6/7 compare lo/hi                  PWM build only
// Writes to channels >= NUM_CH are ignored. Reads from them return 0.
//
// Ports
//   clk         in   1       system clock
//   reset       in   1       synchronous, active-high reset
//   address     in   ADDR_W  word address (register / channel)
//   chipselect  in   1       slave select
//   write_n     in   1       active-low write strobe
//   writedata   in   16      write data
//   readdata    out  16      registered read data, 1-cycle latency
//   irq         out  1       OR of irq_ch
//   irq_ch      out  NUM_CH  per-channel interrupt (TO & ITO)
//   pwm_out     out  NUM_CH  per-channel PWM output
// ============================================================================
module nios2_timer_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int ADDR_W       = 6,
    parameter int RESET_PERIOD = 99999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_ch,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int              CH_AW   = ADDR_W - 3;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

`ifdef NIOS2_TIMER_MULTI_PWM_EN
    localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
    // When PWM is not built, the PWM control bit is not stored, so it reads 0.
    localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif

    // ------------------------------------------------------------------------
    // Shared bus decode. Each channel checks the channel field itself, so an
    // out-of-range channel index simply matches no channel.
    // ------------------------------------------------------------------------
    logic [CH_AW-1:0] w_chSel;
    logic [2:0]       w_regSel;
    logic             w_wrEn;
    logic [15:0]      w_chRead [NUM_CH];
    logic [15:0]      w_readNext;

    assign w_chSel  = address[ADDR_W-1:3];
    assign w_regSel = address[2:0];
    assign w_wrEn   = chipselect & ~write_n;

    // ------------------------------------------------------------------------
    // Per-channel timer logic
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic [CNT_W-1:0] r_counter;
        logic [CNT_W-1:0] r_period;
        logic [CNT_W-1:0] r_snap;
        logic [CNT_W-1:0] w_compare;
        logic [4:0]       r_control;
        logic             r_run;
        logic             r_to;
        logic             r_forceReload;
        logic             r_wasNonZero;

        logic             w_hit;
        logic [5:0]       w_wr;
        logic             w_cntZero;
        logic             w_timeout;
        logic [31:0]      w_perExt;
        logic [31:0]      w_perLoVal;
        logic [31:0]      w_perHiVal;
        logic [31:0]      w_snapExt;
        logic [31:0]      w_cmpExt;

        assign w_hit = w_wrEn && (w_chSel == CH_AW'(i));

        for (genvar r = 0; r < 6; r++) begin : g_wr
            assign w_wr[r] = w_hit && (w_regSel == 3'(r));
        end

        assign w_cntZero = (r_counter == '0);

        // A timeout is the first cycle the counter sits at zero. This keeps a
        // zero period in continuous mode from raising an event every cycle.
        assign w_timeout = w_cntZero & r_wasNonZero;

        // Writes land on a 32-bit view of the register. The result is then
        // cut back to CNT_W, which drops any bits the counter cannot hold.
        assign w_perExt   = 32'(r_period);
        assign w_perLoVal = {w_perExt[31:16], writedata};
        assign w_perHiVal = {writedata, w_perExt[15:0]};
        assign w_snapExt  = 32'(r_snap);
        assign w_cmpExt   = 32'(w_compare);

        // Main channel state.
        // START takes priority over every stop condition, so a write of
        // START|STOP leaves the channel running.
        // In one-shot mode the counter parks at zero instead of reloading.
        // It stays at zero until a period write forces a reload.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_counter     <= RST_VAL;
                r_period      <= RST_VAL;
                r_snap        <= '0;
                r_control     <= '0;
                r_run         <= 1'b0;
                r_to          <= 1'b0;
                r_forceReload <= 1'b0;
                r_wasNonZero  <= 1'b0;
            end else begin
                r_forceReload <= w_wr[2] | w_wr[3];

                if (w_wr[2]) begin
                    r_period <= w_perLoVal[CNT_W-1:0];
                end else if (w_wr[3]) begin
                    r_period <= w_perHiVal[CNT_W-1:0];
                end

                if (r_run || r_forceReload) begin
                    if (r_forceReload || (w_cntZero && r_control[1])) begin
                        r_counter <= r_period;
                    end else if (!w_cntZero) begin
                        r_counter <= r_counter - CNT_W'(1);
                    end
                end

                if (w_wr[1] && writedata[2]) begin
                    r_run <= 1'b1;
                end else if ((w_wr[1] && writedata[3]) || r_forceReload ||
                             (w_cntZero && !r_control[1])) begin
                    r_run <= 1'b0;
                end

                // A status write clears TO and wins over a timeout in the same cycle.
                if (w_wr[0]) begin
                    r_to <= 1'b0;
                end else if (w_timeout) begin
                    r_to <= 1'b1;
                end

                if (w_wr[4] || w_wr[5]) begin
                    r_snap <= r_counter;
                end

                if (w_wr[1]) begin
                    r_control <= writedata[4:0] & CTRL_MASK;
                end

                r_wasNonZero <= !w_cntZero;
            end
        end

`ifdef NIOS2_TIMER_MULTI_PWM_EN
        logic [CNT_W-1:0] r_compare;
        logic             r_pwm;
        logic             w_wrCmpLo;
        logic             w_wrCmpHi;
        logic [31:0]      w_cmpLoVal;
        logic [31:0]      w_cmpHiVal;

        assign w_wrCmpLo  = w_hit && (w_regSel == 3'd6);
        assign w_wrCmpHi  = w_hit && (w_regSel == 3'd7);
        assign w_cmpLoVal = {w_cmpExt[31:16], writedata};
        assign w_cmpHiVal = {writedata, w_cmpExt[15:0]};
        assign w_compare  = r_compare;
        assign pwm_out[i] = r_pwm;

        // Compare register and PWM output. A compare write takes effect on the
        // next comparison; there is no double-buffering. The PWM bit lags the
        // counter by one cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_compare <= '0;
                r_pwm     <= 1'b0;
            end else begin
                if (w_wrCmpLo) begin
                    r_compare <= w_cmpLoVal[CNT_W-1:0];
                end else if (w_wrCmpHi) begin
                    r_compare <= w_cmpHiVal[CNT_W-1:0];
                end
                r_pwm <= r_run & r_control[4] & (r_counter < r_compare);
            end
        end
`else
        assign w_compare  = '0;
        assign pwm_out[i] = 1'b0;
`endif

        assign irq_ch[i] = r_to & r_control[0];

        // Read value for this channel. The top-level mux selects among channels.
        always_comb begin
            w_chRead[i] = '0;
            case (w_regSel)
                3'd0:    w_chRead[i] = {14'd0, r_run, r_to};
                3'd1:    w_chRead[i] = {11'd0, r_control};
                3'd2:    w_chRead[i] = w_perExt[15:0];
                3'd3:    w_chRead[i] = w_perExt[31:16];
                3'd4:    w_chRead[i] = w_snapExt[15:0];
                3'd5:    w_chRead[i] = w_snapExt[31:16];
                3'd6:    w_chRead[i] = w_cmpExt[15:0];
                default: w_chRead[i] = w_cmpExt[31:16];
            endcase
        end
    end

    assign irq = |irq_ch;

    // Channel read mux. An index with no matching channel returns 0.
    always_comb begin
        w_readNext = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_chSel == CH_AW'(c)) begin
                w_readNext = w_chRead[c];
            end
        end
    end

    // Read data updates every cycle from address, whether or not chipselect is
    // asserted. This gives a fixed 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_readNext;
        end
    end

endmodule
